// File: rtl/caliptra_ext_xccm_loader.sv
// Backdoor preload engine: SECDED-encodes a 32-bit word stream and writes it into ICCM, DCCM
// or mailbox SRAM at consecutive word addresses, one word per cycle, with no CPU involvement.
module caliptra_ext_xccm_loader #(
    parameter int unsigned ICCM_DEPTH = 8192,
    parameter int unsigned DCCM_DEPTH = 8192,
    parameter int unsigned MBOX_DEPTH = 32768
) (
    input  logic         core_clk,
    input  logic         core_rst,
    input  logic         start,
    input  logic [1:0]   target,
    input  logic [14:0]  base_addr,
    input  logic [15:0]  word_count,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  words_written,
    output logic         ext_iccm_we,
    output logic         ext_dccm_we,
    output logic         ext_mbox_we,
    output logic [14:0]  ext_xccm_addr,
    output logic [155:0] ext_xccm_wdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [1:0] TGT_ICCM = 2'd0;
    localparam logic [1:0] TGT_DCCM = 2'd1;
    localparam logic [1:0] TGT_MBOX = 2'd2;

    localparam logic [16:0] ICCM_LIMIT = 17'(ICCM_DEPTH);
    localparam logic [16:0] DCCM_LIMIT = 17'(DCCM_DEPTH);
    localparam logic [16:0] MBOX_LIMIT = 17'(MBOX_DEPTH);

    // Hamming parity masks matching the VeeR rvecc_encode equations; ecc[6] is overall parity.
    function automatic logic [6:0] secded_enc(input logic [31:0] d);
        logic [5:0] p;
        p[0] = ^(d & 32'h56AA_AD5B);
        p[1] = ^(d & 32'h9B33_366D);
        p[2] = ^(d & 32'hE3C3_C78E);
        p[3] = ^(d & 32'h03FC_07F0);
        p[4] = ^(d & 32'h03FF_F800);
        p[5] = ^(d & 32'hFC00_0000);
        return {^{p, d}, p};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  target_q, target_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [14:0] wr_addr_q, wr_addr_d;
    logic [38:0] wr_cw_q, wr_cw_d;
    logic        we_q, we_d;
    logic [15:0] words_written_q, words_written_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [16:0] job_end;
    logic [16:0] job_limit;
    logic        job_bad;
    logic        accept;

    always_comb begin
        job_end = {2'b00, base_addr} + {1'b0, word_count};
        case (target)
            TGT_ICCM: job_limit = ICCM_LIMIT;
            TGT_DCCM: job_limit = DCCM_LIMIT;
            TGT_MBOX: job_limit = MBOX_LIMIT;
            default:  job_limit = 17'd0;
        endcase
        job_bad = (target == 2'd3) || (job_end > job_limit);
    end

    assign accept = (state_q == ST_LOAD) && in_valid;

    // The strobe stage is one register deep, so every accept becomes a write exactly one cycle later.
    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        wr_addr_d       = wr_addr_q;
        wr_cw_d         = wr_cw_q;
        we_d            = 1'b0;
        words_written_d = words_written_q + 16'(we_q);
        err_d           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (job_bad) begin
                        err_d = 1'b1;
                    end else begin
                        target_d        = target;
                        words_written_d = 16'd0;
                        if (word_count == 16'd0) begin
                            state_d = ST_FIN;
                        end else begin
                            addr_d      = base_addr;
                            remaining_d = word_count;
                            state_d     = ST_LOAD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_cw_d     = {secded_enc(in_data), in_data};
                    wr_addr_d   = addr_q;
                    addr_d      = addr_q + 15'd1;
                    remaining_d = remaining_q - 16'd1;
                    we_d        = 1'b1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_FIN;
            default:  state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q         <= ST_IDLE;
            target_q        <= 2'd0;
            addr_q          <= 15'd0;
            remaining_q     <= 16'd0;
            wr_addr_q       <= 15'd0;
            wr_cw_q         <= 39'd0;
            we_q            <= 1'b0;
            words_written_q <= 16'd0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            wr_addr_q       <= wr_addr_d;
            wr_cw_q         <= wr_cw_d;
            we_q            <= we_d;
            words_written_q <= words_written_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign in_ready       = (state_q == ST_LOAD);
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign words_written  = words_written_q;
    assign ext_iccm_we    = we_q && (target_q == TGT_ICCM);
    assign ext_dccm_we    = we_q && (target_q == TGT_DCCM);
    assign ext_mbox_we    = we_q && (target_q == TGT_MBOX);
    assign ext_xccm_addr  = wr_addr_q;
    assign ext_xccm_wdata = {4{wr_cw_q}};

endmodule
